// File: rtl/cache_ctrl_assoc.sv
// Sequencer for a 1- or 2-way write-back, write-allocate cache in front of a banked memory.
// Handles MRU victim choice, pipelined fill/evict beats, bank back-pressure and errors.
module cache_ctrl_assoc #(
  parameter int unsigned WAYS    = 2,
  parameter int unsigned SETS    = 256,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned OFF_W   = 2,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [WAYS-1:0]  hit_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAYS-1:0]  dirty_i,
  input  logic             cache_err_i,
  input  logic             mem_err_i,
  input  logic [BEATS-1:0] busy_i,
  output logic             comp_o,
  output logic             cache_wr_o,
  output logic [WAYS-1:0]  way_sel_o,
  output logic [OFF_W-1:0] word_off_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic [OFF_W-1:0] mem_off_o,
  output logic             fill_src_o,
  output logic             done_o,
  output logic             cache_hit_o,
  output logic             err_o,
  output logic             stall_out_o
);

  typedef enum logic [2:0] {
    StIdle, StCmpHit, StAlloc, StEvict, StFill, StFinal, StDone, StErr
  } state_e;

  localparam logic [OFF_W:0]   NumBeats = (OFF_W + 1)'(BEATS);
  localparam logic [OFF_W-1:0] LastOff  = OFF_W'(BEATS - 1);

  state_e                        state_q, state_d;
  logic [OFF_W:0]                cnt_q, cnt_d;
  logic [OFF_W-1:0]              ret_q, ret_d;
  logic                          way_q, way_d;
  logic                          wr_q, wr_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [SETS-1:0]               mru_q, mru_d;
  logic [MEM_LAT-1:0]            pvld_q, pvld_d;
  logic [MEM_LAT-1:0][OFF_W-1:0] poff_q, poff_d;

  logic            fault, hit_way, victim;
  logic [WAYS-1:0] hv;
  logic [OFF_W-1:0] k;

  assign fault   = cache_err_i | mem_err_i;
  assign hv      = hit_i & valid_i;
  assign hit_way = (WAYS > 1) ? ~hv[0] : 1'b0;
  assign k       = cnt_q[OFF_W-1:0];

  // Lowest invalid way first, otherwise the way that was not most recently used.
  always_comb begin
    if (WAYS == 1 || !valid_i[0]) victim = 1'b0;
    else if (!valid_i[WAYS-1])    victim = 1'b1;
    else                          victim = ~mru_q[idx_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    way_d   = way_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    mru_d   = mru_q;
    pvld_d[0] = 1'b0;
    poff_d[0] = k;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      pvld_d[i] = pvld_q[i-1];
      poff_d[i] = poff_q[i-1];
    end
    comp_o      = 1'b1;
    cache_wr_o  = 1'b0;
    way_sel_o   = '0;
    word_off_o  = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_off_o   = '0;
    fill_src_o  = 1'b0;
    done_o      = 1'b0;
    cache_hit_o = 1'b0;
    err_o       = 1'b0;
    stall_out_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        cache_wr_o  = rst_ni & wr_i & (|hit_i);
        stall_out_o = rst_ni & (rd_i | wr_i);
        if (rd_i | wr_i) begin
          idx_d = index_i;
          wr_d  = wr_i;
        end
        if (rd_i & wr_i) begin
          state_d = StErr;
        end else if ((rd_i | wr_i) & (|hv)) begin
          state_d = StCmpHit;
          way_d   = hit_way;
        end else if (rd_i | wr_i) begin
          state_d = StAlloc;
        end
      end
      StCmpHit: begin
        way_sel_o = WAYS'(1) << way_q;
        if (fault) begin
          state_d = StErr;
        end else begin
          done_o        = 1'b1;
          cache_hit_o   = 1'b1;
          mru_d[idx_q]  = way_q;
          state_d       = StIdle;
        end
      end
      StAlloc: begin
        stall_out_o = 1'b1;
        cnt_d       = '0;
        ret_d       = '0;
        if (fault || (|(dirty_i & ~valid_i))) begin
          state_d = StErr;
        end else begin
          way_d   = victim;
          state_d = (dirty_i[victim] & valid_i[victim]) ? StEvict : StFill;
        end
      end
      StEvict: begin
        stall_out_o = 1'b1;
        comp_o      = 1'b0;
        way_sel_o   = WAYS'(1) << way_q;
        word_off_o  = k;
        mem_off_o   = k;
        if (fault) begin
          state_d = StErr;
        end else if (!busy_i[k]) begin
          mem_wr_o = 1'b1;
          if (k == LastOff) begin
            cnt_d   = '0;
            state_d = StFill;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFill: begin
        stall_out_o = 1'b1;
        comp_o      = 1'b0;
        way_sel_o   = WAYS'(1) << way_q;
        mem_off_o   = k;
        if (fault) begin
          state_d = StErr;
        end else begin
          if (cnt_q < NumBeats && !busy_i[k]) begin
            mem_rd_o  = 1'b1;
            pvld_d[0] = 1'b1;
            cnt_d     = cnt_q + 1'b1;
          end
          if (pvld_q[MEM_LAT-1]) begin
            cache_wr_o = 1'b1;
            fill_src_o = 1'b1;
            word_off_o = poff_q[MEM_LAT-1];
            if (ret_q == LastOff) begin
              ret_d   = '0;
              cnt_d   = '0;
              state_d = StFinal;
            end else begin
              ret_d = ret_q + 1'b1;
            end
          end
        end
      end
      StFinal: begin
        stall_out_o = 1'b1;
        way_sel_o   = WAYS'(1) << way_q;
        if (fault) begin
          state_d = StErr;
        end else begin
          cache_wr_o = wr_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (fault) begin
          state_d = StErr;
        end else begin
          done_o       = 1'b1;
          mru_d[idx_q] = way_q;
          state_d      = StIdle;
        end
      end
      StErr: begin
        err_o   = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
    endcase

    // Reads still in flight are dropped whenever the fill phase ends.
    if (state_d != StFill) pvld_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ret_q   <= '0;
      way_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      mru_q   <= '0;
      pvld_q  <= '0;
      poff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      way_q   <= way_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      mru_q   <= mru_d;
      pvld_q  <= pvld_d;
      poff_q  <= poff_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Self-checking bench for cache_ctrl_assoc: directed vector table, reset corners and
// randomized transactions scored against a transaction-level timing model.
module tb_cache_ctrl_assoc;

  localparam int BEATS   = 4;
  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd, wr;
  logic [7:0] index;
  logic [1:0] hit, valid, dirty;
  logic       cache_err, mem_err;
  logic [3:0] busy;
  logic       comp, cache_wr, mem_rd, mem_wr, fill_src, done, cache_hit, err, stall;
  logic [1:0] way_sel, word_off, mem_off;

  cache_ctrl_assoc dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_i        (rd),
    .wr_i        (wr),
    .index_i     (index),
    .hit_i       (hit),
    .valid_i     (valid),
    .dirty_i     (dirty),
    .cache_err_i (cache_err),
    .mem_err_i   (mem_err),
    .busy_i      (busy),
    .comp_o      (comp),
    .cache_wr_o  (cache_wr),
    .way_sel_o   (way_sel),
    .word_off_o  (word_off),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_off_o   (mem_off),
    .fill_src_o  (fill_src),
    .done_o      (done),
    .cache_hit_o (cache_hit),
    .err_o       (err),
    .stall_out_o (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] idx;
    logic [1:0] hit;
    logic [1:0] valid;
    logic [1:0] dirty;
    int         bbank;
    int         bstart;
    int         blen;
    int         err_at;
    int         lat;
    logic       xhit;
    logic       xerr;
    int         victim;
    int         mwr;
    int         mrd;
    logic       fwr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit [255:0] mru_m;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] busy_at(input vec_t v, input int c);
    if (v.blen > 0 && c >= v.bstart && c < v.bstart + v.blen) return 4'b0001 << v.bbank;
    return 4'b0000;
  endfunction

  // Transaction-level expectation: phase lengths plus one cycle per blocked issue beat.
  function automatic vec_t model(input vec_t vin);
    vec_t v = vin;
    logic [1:0] hv = vin.hit & vin.valid;
    logic [3:0] b;
    int c, kk;
    v.xhit = 0; v.xerr = 0; v.victim = 0; v.mwr = 0; v.mrd = 0; v.fwr = 0;
    if (v.rd && v.wr) begin
      v.lat = 1; v.xerr = 1;
    end else if (hv != 0) begin
      v.lat = 1; v.xhit = 1;
    end else if ((v.dirty & ~v.valid) != 0) begin
      v.lat = 2; v.xerr = 1;
    end else begin
      if (!v.valid[0])      v.victim = 0;
      else if (!v.valid[1]) v.victim = 1;
      else                  v.victim = mru_m[v.idx] ? 0 : 1;
      c = 2;
      if (v.dirty[v.victim]) begin
        kk = 0;
        while (kk < BEATS) begin
          b = busy_at(v, c);
          if (!b[kk]) kk++;
          c++;
        end
        v.mwr = BEATS;
      end
      kk = 0;
      while (kk < BEATS) begin
        b = busy_at(v, c);
        if (!b[kk]) kk++;
        c++;
      end
      v.mrd = BEATS;
      v.lat = (c - 1) + MEM_LAT + 2;
      v.fwr = v.wr;
    end
    if (!v.xerr && v.err_at > 0 && v.err_at <= v.lat) begin
      v.lat = v.err_at + 1; v.xerr = 1; v.xhit = 0;
    end
    return v;
  endfunction

  task automatic run(input vec_t v);
    int lat_seen = -1;
    int mwr_n = 0, mrd_n = 0, fills = 0;
    logic fwr_seen = 0, ord_ok = 1, way_ok = 1, dhit = 0, derr = 0;
    logic [3:0] mask = 0;
    logic [1:0] hv;
    @(posedge clk); #1;
    rd = v.rd; wr = v.wr; index = v.idx; hit = v.hit; valid = v.valid; dirty = v.dirty;
    busy = busy_at(v, 0); mem_err = 0; cache_err = 0;
    @(negedge clk);
    chk("idle_done_low", done, 0);
    chk("accept_cache_wr", cache_wr, v.wr & (|v.hit));
    chk("accept_stall", stall, 1);
    for (int c = 1; c <= 60 && lat_seen < 0; c++) begin
      @(posedge clk); #1;
      rd = 0; wr = 0; busy = busy_at(v, c);
      mem_err   = (v.err_at == c) && (c % 2 == 1);
      cache_err = (v.err_at == c) && (c % 2 == 0);
      @(negedge clk);
      if (mem_wr) begin
        if (mem_off != 2'(mwr_n)) ord_ok = 0;
        mwr_n++;
      end
      if (mem_rd) begin
        if (mem_off != 2'(mrd_n)) ord_ok = 0;
        mrd_n++;
      end
      if (cache_wr && fill_src) begin
        fills++;
        mask[word_off] = 1'b1;
        if (way_sel != 2'(1 << v.victim)) way_ok = 0;
      end
      if (cache_wr && !fill_src) fwr_seen = 1;
      if (done) begin
        lat_seen = c; dhit = cache_hit; derr = err;
      end
    end
    busy = 0; mem_err = 0; cache_err = 0;
    chk("latency", lat_seen, v.lat);
    chk("cache_hit", dhit, v.xhit);
    chk("err", derr, v.xerr);
    if (!v.xerr && !v.xhit) begin
      chk("mem_wr_beats", mwr_n, v.mwr);
      chk("mem_rd_beats", mrd_n, v.mrd);
      chk("fill_writes", fills, BEATS);
      chk("fill_offsets", mask, 4'hf);
      chk("fill_way", way_ok, 1);
      chk("beat_order", ord_ok, 1);
      chk("final_wr", fwr_seen, v.fwr);
    end
    if (!v.xerr) begin
      hv = v.hit & v.valid;
      mru_m[v.idx] = v.xhit ? ~hv[0] : v.victim[0];
    end
  endtask

  function automatic logic [14:0] outs();
    return {comp, cache_wr, way_sel, word_off, mem_rd, mem_wr, mem_off,
            fill_src, done, cache_hit, err, stall};
  endfunction

  initial begin
    vec_t v;
    logic quiet;
    int r;
    rst_n = 0; rd = 1; wr = 0; index = 8'd5; hit = 2'b11; valid = 2'b11; dirty = 2'b00;
    cache_err = 0; mem_err = 0; busy = 0; mru_m = '0;
    #12;
    chk("reset_outputs", outs(), 15'h4000);
    rd = 0;
    @(negedge clk); rst_n = 1;

    //           rd wr idx  hit    valid  dirty  bk st ln ea lat hit err vic mwr mrd fwr
    tbl[0]  = '{1, 0, 5, 2'b10, 2'b11, 2'b00, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 5, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 9,  0, 0, 0, 0, 4, 0};
    tbl[2]  = '{0, 1, 5, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0, 13, 0, 0, 1, 4, 4, 1};
    tbl[3]  = '{1, 0, 7, 2'b00, 2'b01, 2'b00, 2, 4, 3, 0, 12, 0, 0, 1, 0, 4, 0};
    tbl[4]  = '{0, 1, 5, 2'b00, 2'b11, 2'b11, 0, 0, 0, 3, 4,  0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 5, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 5, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 9,  0, 0, 0, 0, 4, 0};
    tbl[7]  = '{1, 0, 9, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 9,  0, 0, 0, 0, 4, 0};
    tbl[8]  = '{1, 0, 9, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 2,  0, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 9, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 9, 2'b00, 2'b11, 2'b10, 1, 3, 2, 0, 15, 0, 0, 1, 4, 4, 0};
    tbl[11] = '{1, 0, 9, 2'b00, 2'b11, 2'b00, 0, 0, 0, 6, 7,  0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) run(tbl[i]);

    // Reset in the middle of a fill: no more array writes, MRU back to zero.
    @(posedge clk); #1;
    rd = 1; index = 8'd7; hit = 2'b00; valid = 2'b11; dirty = 2'b00;
    @(posedge clk); #1; rd = 0;
    repeat (3) @(posedge clk);
    #2; rst_n = 0;
    #1;
    chk("midfill_reset_outputs", outs(), 15'h4000);
    quiet = 1;
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cache_wr || done || mem_rd) quiet = 0;
    end
    chk("midfill_reset_quiet", quiet, 1);
    mru_m = '0;
    v = '{1, 0, 7, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 9, 0, 0, 1, 0, 4, 0};
    run(v);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      v.rd = (r <= 5); v.wr = (r == 0) || (r >= 6);
      case ($urandom_range(0, 3))
        0: v.idx = 8'd5;
        1: v.idx = 8'd7;
        2: v.idx = 8'd9;
        default: v.idx = 8'd200;
      endcase
      v.hit = 2'($urandom_range(0, 3));
      v.valid = 2'($urandom_range(0, 3));
      v.dirty = 2'($urandom_range(0, 3));
      v.blen = $urandom_range(0, 3);
      v.bbank = $urandom_range(0, 3);
      v.bstart = $urandom_range(2, 10);
      v.err_at = (!(v.rd && v.wr) && $urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0;
      v = model(v);
      run(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
